// File: rtl/spi_pwm_config_if.sv
// SPI pin bundle between an external controller and the PWM configuration target.
// Pins: sclk (idle low, mode 0), copi (MSB first), ncs (active low), cipo.
interface spi_pwm_config_if;
    logic sclk;
    logic copi;
    logic ncs;
    logic cipo;

    modport master (
        output sclk,
        output copi,
        output ncs,
        input  cipo
    );

    modport slave (
        input  sclk,
        input  copi,
        input  ncs,
        output cipo
    );
endinterface

// File: rtl/spi_pwm_config.sv
// SPI write target holding the five PWM configuration bytes, synchronised into clk.
// Optional feature: define SPI_READBACK_EN to shift the addressed register out on cipo during read frames.
module spi_pwm_config #(
    parameter int unsigned MAX_ADDR = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    spi_pwm_config_if.slave     spi,
    output logic [7:0]          en_reg_out_7_0,
    output logic [7:0]          en_reg_out_15_8,
    output logic [7:0]          en_reg_pwm_7_0,
    output logic [7:0]          en_reg_pwm_15_8,
    output logic [7:0]          pwm_duty_cycle,
    output logic                wr_strobe
);

    localparam int unsigned FRAME_BITS = 16;
    localparam int unsigned CNT_W      = 5;
    localparam int unsigned ADDR_W     = 7;
    localparam int unsigned DATA_W     = 8;
    localparam int unsigned NUM_REGS   = 5;
    localparam int unsigned IDX_W      = $clog2(NUM_REGS);
    localparam int unsigned HDR_BITS   = 8;

    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(FRAME_BITS);
    localparam logic [CNT_W-1:0]  CNT_OVR  = CNT_W'(FRAME_BITS + 1);
    localparam logic [ADDR_W-1:0] ADDR_MAX = ADDR_W'(MAX_ADDR);
    localparam logic [ADDR_W-1:0] ADDR_LIM = ADDR_W'(NUM_REGS);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_COMMIT
    } state_e;

    state_e                state_q, state_d;
    logic [2:0]            sclk_sync_q, sclk_sync_d;
    logic [2:0]            ncs_sync_q, ncs_sync_d;
    logic [1:0]            copi_sync_q, copi_sync_d;
    logic [FRAME_BITS-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_W-1:0]     regs_q [NUM_REGS];
    logic [DATA_W-1:0]     regs_d [NUM_REGS];
    logic                  wr_strobe_q, wr_strobe_d;

    logic                  sclk_rise_c;
    logic                  ncs_fall_c;
    logic                  ncs_rise_c;
    logic                  copi_bit_c;
    logic                  frm_write_c;
    logic [ADDR_W-1:0]     frm_addr_c;
    logic [DATA_W-1:0]     frm_data_c;
    logic                  frm_addr_ok_c;
    logic [IDX_W-1:0]      frm_idx_c;

    // Synchroniser chains; the third stage on sclk and ncs feeds edge detection.
    always_comb begin
        sclk_sync_d = {sclk_sync_q[1:0], spi.sclk};
        ncs_sync_d  = {ncs_sync_q[1:0],  spi.ncs};
        copi_sync_d = {copi_sync_q[0],   spi.copi};
    end

    assign sclk_rise_c = sclk_sync_q[1] & ~sclk_sync_q[2];
    assign ncs_fall_c  = ~ncs_sync_q[1] &  ncs_sync_q[2];
    assign ncs_rise_c  =  ncs_sync_q[1] & ~ncs_sync_q[2];
    assign copi_bit_c  = copi_sync_q[1];

    assign frm_write_c   = shift_q[FRAME_BITS-1];
    assign frm_addr_c    = shift_q[FRAME_BITS-2:DATA_W];
    assign frm_data_c    = shift_q[DATA_W-1:0];
    assign frm_addr_ok_c = (frm_addr_c <= ADDR_MAX) && (frm_addr_c < ADDR_LIM);
    assign frm_idx_c     = frm_addr_c[IDX_W-1:0];

    // Frame FSM: capture bits between ncs edges, commit only exact-length mapped writes.
    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        cnt_d       = cnt_q;
        regs_d      = regs_q;
        wr_strobe_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (ncs_fall_c) begin
                    state_d = ST_SHIFT;
                    shift_d = '0;
                    cnt_d   = '0;
                end
            end
            ST_SHIFT: begin
                if (sclk_rise_c) begin
                    shift_d = {shift_q[FRAME_BITS-2:0], copi_bit_c};
                    if (cnt_q != CNT_OVR) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                if (ncs_rise_c) begin
                    state_d = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                if ((cnt_q == CNT_FULL) && frm_write_c && frm_addr_ok_c) begin
                    regs_d[frm_idx_c] = frm_data_c;
                    wr_strobe_d       = 1'b1;
                end
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            sclk_sync_q <= 3'b000;
            ncs_sync_q  <= 3'b111;
            copi_sync_q <= 2'b00;
            shift_q     <= '0;
            cnt_q       <= '0;
            wr_strobe_q <= 1'b0;
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            sclk_sync_q <= sclk_sync_d;
            ncs_sync_q  <= ncs_sync_d;
            copi_sync_q <= copi_sync_d;
            shift_q     <= shift_d;
            cnt_q       <= cnt_d;
            wr_strobe_q <= wr_strobe_d;
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    assign en_reg_out_7_0  = regs_q[0];
    assign en_reg_out_15_8 = regs_q[1];
    assign en_reg_pwm_7_0  = regs_q[2];
    assign en_reg_pwm_15_8 = regs_q[3];
    assign pwm_duty_cycle  = regs_q[4];
    assign wr_strobe       = wr_strobe_q;

`ifdef SPI_READBACK_EN
    localparam logic [CNT_W-1:0] CNT_HDR = CNT_W'(HDR_BITS);

    logic              cipo_q, cipo_d;
    logic [DATA_W-1:0] rd_shift_q, rd_shift_d;
    logic              sclk_fall_c;
    logic [ADDR_W-1:0] rd_addr_c;
    logic              rd_addr_ok_c;
    logic [DATA_W-1:0] rd_load_c;

    assign sclk_fall_c  = ~sclk_sync_q[1] & sclk_sync_q[2];
    // After 8 rising edges the header (R/W + address) sits in the low byte of the shift register.
    assign rd_addr_c    = shift_q[ADDR_W-1:0];
    assign rd_addr_ok_c = (rd_addr_c <= ADDR_MAX) && (rd_addr_c < ADDR_LIM);
    assign rd_load_c    = (!shift_q[HDR_BITS-1] && rd_addr_ok_c) ? regs_q[rd_addr_c[IDX_W-1:0]] : '0;

    always_comb begin
        cipo_d     = cipo_q;
        rd_shift_d = rd_shift_q;
        if ((state_q != ST_SHIFT) || ncs_sync_q[1]) begin
            cipo_d     = 1'b0;
            rd_shift_d = '0;
        end else if (sclk_fall_c) begin
            if (cnt_q == CNT_HDR) begin
                cipo_d     = rd_load_c[DATA_W-1];
                rd_shift_d = {rd_load_c[DATA_W-2:0], 1'b0};
            end else if ((cnt_q > CNT_HDR) && (cnt_q < CNT_FULL)) begin
                cipo_d     = rd_shift_q[DATA_W-1];
                rd_shift_d = {rd_shift_q[DATA_W-2:0], 1'b0};
            end else begin
                cipo_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cipo_q     <= 1'b0;
            rd_shift_q <= '0;
        end else begin
            cipo_q     <= cipo_d;
            rd_shift_q <= rd_shift_d;
        end
    end

    assign spi.cipo = cipo_q;
`else
    assign spi.cipo = 1'b0;
`endif

endmodule

// File: tb/tb_spi_pwm_config.sv
// Self-checking bench for spi_pwm_config: scoreboard of expected register writes plus register/cipo checks.
module tb_spi_pwm_config;

    localparam int HALF = 6;
    localparam int LAT_NOM = 4;

    typedef struct packed {
        logic [2:0] addr;
        logic [7:0] data;
    } wr_exp_t;

    logic clk;
    logic rst_n;
    logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle;
    logic wr_strobe;

    spi_pwm_config_if spi_if ();

    spi_pwm_config #(.MAX_ADDR(4)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .spi             (spi_if.slave),
        .en_reg_out_7_0  (en_reg_out_7_0),
        .en_reg_out_15_8 (en_reg_out_15_8),
        .en_reg_pwm_7_0  (en_reg_pwm_7_0),
        .en_reg_pwm_15_8 (en_reg_pwm_15_8),
        .pwm_duty_cycle  (pwm_duty_cycle),
        .wr_strobe       (wr_strobe)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int ncs_rise_cyc = 0;
    wr_exp_t exp_q[$];
    logic [7:0] model [5];

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [39:0] got, input logic [39:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] reg_at(input logic [2:0] a);
        case (a)
            3'd0:    reg_at = en_reg_out_7_0;
            3'd1:    reg_at = en_reg_out_15_8;
            3'd2:    reg_at = en_reg_pwm_7_0;
            3'd3:    reg_at = en_reg_pwm_15_8;
            3'd4:    reg_at = pwm_duty_cycle;
            default: reg_at = 8'h00;
        endcase
    endfunction

    // Scoreboard side: every strobe must match the oldest pending write, within the commit latency window.
    always @(negedge clk) begin
        if (rst_n && wr_strobe) begin
            if (exp_q.size() == 0) begin
                check("unexpected_strobe", 40'd1, 40'd0);
            end else begin
                automatic wr_exp_t e = exp_q.pop_front();
                automatic int d = cyc - ncs_rise_cyc;
                check("wr_data", 40'(reg_at(e.addr)), 40'(e.data));
                check("wr_latency_in_window", 40'((d >= LAT_NOM - 1) && (d <= LAT_NOM + 1)), 40'd1);
            end
        end
    end

    task automatic spi_bits(input logic [16:0] bits, input int n, output logic [15:0] rx);
        rx = '0;
        for (int i = 0; i < n; i++) begin
            spi_if.copi = bits[n-1-i];
            repeat (HALF) @(negedge clk);
            if (i < 16) rx = {rx[14:0], spi_if.cipo};
            spi_if.sclk = 1'b1;
            repeat (HALF) @(negedge clk);
            spi_if.sclk = 1'b0;
        end
    endtask

    task automatic spi_frame(input logic [16:0] bits, input int n, output logic [15:0] rx);
        @(negedge clk);
        spi_if.ncs = 1'b0;
        repeat (HALF) @(negedge clk);
        spi_bits(bits, n, rx);
        repeat (HALF) @(negedge clk);
        spi_if.ncs   = 1'b1;
        spi_if.copi  = 1'b0;
        ncs_rise_cyc = cyc;
        repeat (12) @(negedge clk);
    endtask

    task automatic check_regs(input string tag);
        check(tag, {pwm_duty_cycle, en_reg_pwm_15_8, en_reg_pwm_7_0, en_reg_out_15_8, en_reg_out_7_0},
              {model[4], model[3], model[2], model[1], model[0]});
        check("sb_drained", 40'(exp_q.size()), 40'd0);
    endtask

    task automatic do_write(input logic [6:0] addr, input logic [7:0] data);
        logic [15:0] rx;
        if (addr <= 7'd4) begin
            exp_q.push_back('{addr: addr[2:0], data: data});
            model[addr[2:0]] = data;
        end
        spi_frame({1'b0, 1'b1, addr, data}, 16, rx);
        check_regs("regs_after_write");
    endtask

    task automatic do_read(input logic [6:0] addr);
        logic [15:0] rx;
        logic [15:0] exp_rx;
        exp_rx = 16'h0000;
`ifdef SPI_READBACK_EN
        if (addr <= 7'd4) exp_rx = {8'h00, model[addr[2:0]]};
`endif
        spi_frame({1'b0, 1'b0, addr, 8'h00}, 16, rx);
        check("cipo_readback", 40'(rx), 40'(exp_rx));
        check_regs("regs_after_read");
    endtask

    initial begin
        logic [15:0] rx;
        rst_n = 1'b0;
        spi_if.sclk = 1'b0;
        spi_if.copi = 1'b0;
        spi_if.ncs  = 1'b1;
        for (int i = 0; i < 5; i++) model[i] = 8'h00;
        repeat (5) @(negedge clk);
        check("reset_regs", {pwm_duty_cycle, en_reg_pwm_15_8, en_reg_pwm_7_0, en_reg_out_15_8, en_reg_out_7_0}, 40'd0);
        check("reset_strobe", 40'(wr_strobe), 40'd0);
        check("reset_cipo", 40'(spi_if.cipo), 40'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        do_write(7'h00, 8'hFF);
        do_write(7'h04, 8'h80);
        do_write(7'h05, 8'h80);

        // 15-bit and 17-bit frames carrying 0x8255 must be dropped.
        spi_frame(17'(16'h8255 >> 1), 15, rx);
        check_regs("regs_after_short");
        spi_frame({16'h8255, 1'b0}, 17, rx);
        check_regs("regs_after_long");

        do_write(7'h01, 8'hA5);
        do_read(7'h01);
        do_read(7'h00);
        do_read(7'h06);

        for (int k = 0; k < 6; k++) begin
            do_write(7'($urandom_range(0, 6)), 8'($urandom_range(0, 255)));
        end

        // Reset in the middle of a frame: nothing commits, and a fresh frame is required.
        @(negedge clk);
        spi_if.ncs = 1'b0;
        repeat (HALF) @(negedge clk);
        spi_bits(17'(16'h83C3 >> 6), 10, rx);
        rst_n = 1'b0;
        for (int i = 0; i < 5; i++) model[i] = 8'h00;
        repeat (3) @(negedge clk);
        spi_if.ncs  = 1'b1;
        spi_if.copi = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        check_regs("regs_after_midframe_reset");
        do_write(7'h03, 8'hC3);
        do_read(7'h03);

        repeat (10) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/spi_pwm_config.md
# spi_pwm_config

SPI target that owns the PWM peripheral's configuration registers. It receives 16-bit write frames from an external SPI controller on three dedicated input pins, synchronises them into the system clock domain, and drives the five configuration bytes (output enables, PWM enables, duty cycle) consumed by the PWM peripheral. It sits in the top level between the dedicated input pins and the PWM peripheral's configuration ports.

## Interface
Parameters:
- MAX_ADDR, 4: highest mapped register address; frames addressed above it are discarded.

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- sclk  in  1  SPI clock pin, asynchronous to clk, idle low (mode 0)
- copi  in  1  SPI data in, MSB first
- ncs  in  1  SPI chip select, active low, asynchronous
- cipo  out  1  SPI data out (readback only, see Configuration)
- en_reg_out_7_0  out  8  register 0x00
- en_reg_out_15_8  out  8  register 0x01
- en_reg_pwm_7_0  out  8  register 0x02
- en_reg_pwm_15_8  out  8  register 0x03
- pwm_duty_cycle  out  8  register 0x04
- wr_strobe  out  1  one-cycle pulse the cycle a register is updated

## Operation
- Frame: 16 bits, MSB first. Bit 15 = R/W (1 write, 0 read), bits 14:8 = address (7 bits), bits 7:0 = data.
- sclk, copi, ncs each pass a 2-flop synchroniser; a third flop on sclk and ncs provides edge detection. Reset values: ncs chain 1, sclk/copi chains 0.
- FSM states: IDLE, SHIFT, COMMIT.
  - IDLE: synchronised ncs falling edge -> SHIFT; clear shift register and 5-bit bit counter.
  - SHIFT: each synchronised sclk rising edge shifts copi into bit 0; counter increments, saturating at 17 (17 = overrun). ncs rising edge -> COMMIT.
  - COMMIT (one cycle): if counter == 16, bit 15 == 1 and address <= MAX_ADDR, load data into addressed register and pulse wr_strobe. Otherwise no change. -> IDLE.
- Short (<16 bits) or long (>16 bits) frames discarded entirely.
- Read frames never modify registers.
- Reset: all five registers 0x00, wr_strobe 0, cipo 0, FSM IDLE, counter 0. Reset asserted mid-frame aborts it; the frame is not committed, and the next frame needs a fresh ncs falling edge.
- sclk edges while ncs high are ignored.
- ncs falling edge during COMMIT is not possible (edge detection needs ≥2 cycles); the FSM returns to IDLE and catches it.

## Timing
- Pin-to-edge-detect latency: 3 clk cycles.
- sclk high and low phases each ≥ 4 clk periods; ncs high ≥ 4 clk periods between frames.
- Register outputs and wr_strobe change on the clk edge ending COMMIT: 4 clk cycles after the ncs pin rises (±1 for synchroniser phase).
- Registers hold value indefinitely; no other write path.

## Configuration
- SPI_READBACK_EN defined: on a read frame with address <= MAX_ADDR, at each synchronised sclk falling edge after the 8th rising edge, cipo drives the addressed register's bits 7..0 in order, MSB first, one bit per falling edge. Unmapped addresses read 0x00. cipo = 0 while ncs high, during bits 15:8, and for write frames.
- Undefined: cipo tied to 0; read frames are received and discarded.

## Test plan
- Reset, then write 0x80FF (addr 0x00, data 0xFF) -> en_reg_out_7_0 = 0xFF 4 cycles after ncs rise; one wr_strobe pulse; other registers 0x00.
- Write 0x8480 -> pwm_duty_cycle = 0x80; then write 0x8580 (addr 5) -> no register change, no wr_strobe.
- 15-bit frame and 17-bit frame carrying 0x8255 -> en_reg_pwm_7_0 stays 0x00.
- Read frame 0x0100 after writing 0x81A5 -> en_reg_out_15_8 unchanged at 0xA5; with SPI_READBACK_EN cipo shifts out 1,0,1,0,0,1,0,1 on bits 7..0, else cipo stays 0.
- Assert rst_n low after 10 bits of 0x83C3, release, send full 0x83C3 -> only the second frame commits; en_reg_pwm_15_8 = 0xC3.
